result_unloader: RTL and testbench

- Read-side counterpart to the host-side input loader that fills the pairing core RAM.
- Waits for the core to go idle, then selects REF_RESULT mode and drives a RAM read address.
- After the fixed read latency, captures the 24 parallel result words and streams them out one word per beat over a valid/ready interface.
- Repeats for NUM consecutive RAM addresses.

---
 rtl/result_unloader_pkg.sv | 26 ++
 rtl/result_unloader_if.sv | 26 ++
 rtl/result_shadow_mux.sv | 38 +++
 rtl/result_unloader.sv | 98 +++++++++
 tb/tb_result_unloader.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_unloader_pkg.sv
// Shared widths, core mode encodings and FSM states for the result unloader.
// RESULT_CHECKSUM_EN adds a 25th XOR beat to every element.
package result_unloader_pkg;
    localparam int WORD_SIZE        = 64;
    localparam int RAM_ADDR_SIZE    = 8;
    localparam int RD_LAT           = 3;
    localparam int CNT_SIZE         = 8;
    localparam int I_INPUTMODE_SIZE = 3;
    localparam int NUM_WORDS        = 24;
    localparam int IDX_SIZE         = 5;
    localparam int LAT_SIZE         = $clog2(RD_LAT + 1);
`ifdef RESULT_CHECKSUM_EN
    localparam int NUM_BEATS        = NUM_WORDS + 1;
`else
    localparam int NUM_BEATS        = NUM_WORDS;
`endif
    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(NUM_BEATS - 1);

    localparam logic [I_INPUTMODE_SIZE-1:0] INPUT_COORD_CORE = 3'd0;
    localparam logic [I_INPUTMODE_SIZE-1:0] REF_RESULT       = 3'd4;
    localparam logic [RAM_ADDR_SIZE-1:0]    RAM_P_BT_0       = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAITCORE, ST_READ, ST_SEND, ST_DONE
    } state_t;
endpackage

// File: rtl/result_unloader_if.sv
// Control, core-side and stream signals of the result unloader.
interface result_unloader_if;
    import result_unloader_pkg::*;
    logic                            i_start;
    logic [RAM_ADDR_SIZE-1:0]        i_base_addr;
    logic [CNT_SIZE-1:0]             i_num;
    logic                            i_core_busy;
    logic [NUM_WORDS*WORD_SIZE-1:0]  i_result;
    logic [I_INPUTMODE_SIZE-1:0]     o_inputmode;
    logic [RAM_ADDR_SIZE-1:0]        o_raddr;
    logic [WORD_SIZE-1:0]            o_data;
    logic                            o_valid;
    logic                            i_ready;
    logic                            o_last;
    logic                            o_busy;
    logic                            o_done;

    modport slave (
        input  i_start, i_base_addr, i_num, i_core_busy, i_result, i_ready,
        output o_inputmode, o_raddr, o_data, o_valid, o_last, o_busy, o_done
    );
    modport master (
        output i_start, i_base_addr, i_num, i_core_busy, i_result, i_ready,
        input  o_inputmode, o_raddr, o_data, o_valid, o_last, o_busy, o_done
    );
endinterface

// File: rtl/result_shadow_mux.sv
// 24-word capture register with beat-index read mux; RESULT_CHECKSUM_EN adds
// an XOR of the captured words served at the beat after the last word.
module result_shadow_mux
    import result_unloader_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [NUM_WORDS*WORD_SIZE-1:0] result,
    input  logic [IDX_SIZE-1:0]            idx,
    output logic [WORD_SIZE-1:0]           data
);
    logic [NUM_WORDS-1:0][WORD_SIZE-1:0] shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       shadow <= '0;
        else if (load) shadow <= result;
    end

`ifdef RESULT_CHECKSUM_EN
    logic [WORD_SIZE-1:0] csum, csum_d;

    always_comb begin
        csum_d = '0;
        for (int k = 0; k < NUM_WORDS; k++)
            csum_d = csum_d ^ result[k*WORD_SIZE +: WORD_SIZE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       csum <= '0;
        else if (load) csum <= csum_d;
    end

    assign data = (idx < IDX_SIZE'(NUM_WORDS)) ? shadow[idx] : csum;
`else
    assign data = shadow[idx];
`endif
endmodule

// File: rtl/result_unloader.sv
// Reads NUM core RAM elements once the core is idle and streams each element's
// 24 result words over valid/ready. RESULT_CHECKSUM_EN appends an XOR beat.
module result_unloader
    import result_unloader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    result_unloader_if.slave  bus
);
    state_t                   state, state_d;
    logic [RAM_ADDR_SIZE-1:0] addr, raddr;
    logic [CNT_SIZE-1:0]      rem;
    logic [LAT_SIZE-1:0]      lat;
    logic [IDX_SIZE-1:0]      idx;
    logic                     zero_done;
    logic [WORD_SIZE-1:0]     shadow_data;
    logic                     hs, last_beat, cap;

    assign hs        = (state == ST_SEND) && bus.i_ready;
    assign last_beat = (idx == LAST_IDX);
    assign cap       = (state == ST_READ) && (lat == '0);

    result_shadow_mux u_shadow (
        .clk    (clk),
        .rst    (rst),
        .load   (cap),
        .result (bus.i_result),
        .idx    (idx),
        .data   (shadow_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:     if (bus.i_start && bus.i_num != '0) state_d = ST_WAITCORE;
            ST_WAITCORE: if (!bus.i_core_busy) state_d = ST_READ;
            ST_READ:     if (lat == '0) state_d = ST_SEND;
            ST_SEND:     if (hs && last_beat)
                             state_d = (rem == CNT_SIZE'(1)) ? ST_DONE : ST_WAITCORE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Counters and latched address; the zero-count done pulse bypasses the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            raddr     <= '0;
            rem       <= '0;
            lat       <= '0;
            idx       <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= (state == ST_IDLE) && bus.i_start && (bus.i_num == '0);
            case (state)
                ST_IDLE: if (bus.i_start) begin
                    addr <= bus.i_base_addr;
                    rem  <= bus.i_num;
                end
                ST_WAITCORE: if (!bus.i_core_busy) begin
                    raddr <= addr;
                    lat   <= LAT_SIZE'(RD_LAT - 1);
                end
                ST_READ: begin
                    if (lat != '0) lat <= lat - 1'b1;
                    else           idx <= '0;
                end
                ST_SEND: if (hs) begin
                    if (last_beat) begin
                        idx  <= '0;
                        rem  <= rem - 1'b1;
                        addr <= addr + 1'b1;
                    end else begin
                        idx  <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.o_valid     = (state == ST_SEND);
        bus.o_last      = (state == ST_SEND) && last_beat;
        bus.o_data      = (state == ST_SEND) ? shadow_data : '0;
        bus.o_busy      = (state != ST_IDLE);
        bus.o_done      = (state == ST_DONE) || zero_done;
        bus.o_inputmode = (state == ST_READ || state == ST_SEND) ? REF_RESULT : INPUT_COORD_CORE;
    end

    assign bus.o_raddr = raddr;
endmodule

// File: tb/tb_result_unloader.sv
// Scoreboard bench for result_unloader: a RAM model feeds i_result from
// o_raddr, stimulus queues expected beats and addresses, a monitor checks them.
module tb_result_unloader;
    import result_unloader_pkg::*;

    typedef struct packed {
        logic [WORD_SIZE-1:0] d;
        logic                 l;
    } beat_t;

`ifdef RESULT_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_unloader_if rif();
    result_unloader dut (.clk(clk), .rst(rst), .bus(rif.slave));

    logic [WORD_SIZE-1:0]     mem [256][NUM_WORDS];
    beat_t                    exp_q[$];
    logic [RAM_ADDR_SIZE-1:0] addr_q[$];
    int checks = 0, errors = 0, done_cnt = 0, exp_done = 0, beat_cnt = 0;
    int ready_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Reference: element e of a run reads address base+e mod 256 and emits its
    // 24 words in order, optionally followed by their XOR, last flag on the end.
    task automatic model(input logic [RAM_ADDR_SIZE-1:0] base, input int num);
        logic [RAM_ADDR_SIZE-1:0] a;
        logic [WORD_SIZE-1:0]     x;
        beat_t                    b;
        for (int e = 0; e < num; e++) begin
            a = base + RAM_ADDR_SIZE'(e);
            addr_q.push_back(a);
            x = '0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                b.d = mem[a][k];
                b.l = (k == NUM_WORDS - 1) && !CSUM;
                exp_q.push_back(b);
                x = x ^ mem[a][k];
            end
            if (CSUM) begin
                b.d = x;
                b.l = 1'b1;
                exp_q.push_back(b);
            end
        end
        exp_done++;
    endtask

    task automatic pulse_start(input logic [RAM_ADDR_SIZE-1:0] base, input int num);
        @(posedge clk); #1;
        rif.i_start     = 1'b1;
        rif.i_base_addr = base;
        rif.i_num       = CNT_SIZE'(num);
        @(posedge clk); #1;
        rif.i_start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rif.o_busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) fail("idle_timeout");
        chk("done_count", 64'(done_cnt), 64'(exp_done));
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n;
        n = 0;
        while (beat_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) fail("beat_timeout");
    endtask

    // Ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    initial begin
        int cyc;
        cyc = 0;
        rif.i_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (ready_mode)
                0:       rif.i_ready = 1'b1;
                1:       rif.i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rif.i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // RAM model: the result bus follows the current read address.
    initial begin
        rif.i_result = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NUM_WORDS; k++)
                rif.i_result[k*WORD_SIZE +: WORD_SIZE] = mem[rif.o_raddr][k];
        end
    end

    initial begin
        beat_t prev, b;
        bit    stall, prev_ref, ref_now;
        stall = 1'b0;
        prev_ref = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                prev_ref = 1'b0;
                continue;
            end
            if (stall) begin
                chk("stall_valid", 64'(rif.o_valid), 64'd1);
                chk("stall_data", rif.o_data, prev.d);
                chk("stall_last", 64'(rif.o_last), 64'(prev.l));
            end
            ref_now = (rif.o_inputmode == REF_RESULT);
            if (ref_now && !prev_ref) begin
                if (addr_q.size() == 0) fail("raddr_unexpected");
                else chk("raddr", 64'(rif.o_raddr), 64'(addr_q.pop_front()));
            end
            prev_ref = ref_now;
            if (rif.o_valid && rif.i_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) fail("beat_unexpected");
                else begin
                    b = exp_q.pop_front();
                    chk("beat_data", rif.o_data, b.d);
                    chk("beat_last", 64'(rif.o_last), 64'(b.l));
                end
            end
            stall  = rif.o_valid && !rif.i_ready;
            prev.d = rif.o_data;
            prev.l = rif.o_last;
            if (rif.o_done) begin
                done_cnt++;
                chk("done_after_last", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    initial begin
        int n, b0, dsnap;
        rif.i_start = 1'b0;
        rif.i_base_addr = '0;
        rif.i_num = '0;
        rif.i_core_busy = 1'b0;
        for (int a = 0; a < 256; a++)
            for (int k = 0; k < NUM_WORDS; k++)
                mem[a][k] = {$urandom, $urandom};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(rif.o_valid), 64'd0);
        chk("rst_busy", 64'(rif.o_busy), 64'd0);
        chk("rst_done", 64'(rif.o_done), 64'd0);
        chk("rst_last", 64'(rif.o_last), 64'd0);
        chk("rst_data", rif.o_data, 64'd0);
        chk("rst_raddr", 64'(rif.o_raddr), 64'd0);
        chk("rst_mode", 64'(rif.o_inputmode), 64'(INPUT_COORD_CORE));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single element with words 1..24 at RAM_P_BT_0.
        for (int k = 0; k < NUM_WORDS; k++) mem[RAM_P_BT_0][k] = 64'(k + 1);
        model(RAM_P_BT_0, 1);
        pulse_start(RAM_P_BT_0, 1);
        wait_beats(NUM_BEATS, 200);
        chk("done_pulse", 64'(rif.o_done), 64'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(rif.o_done), 64'd0);
        wait_idle(100);

        // Backpressure 1,0,0,1.
        ready_mode = 1;
        model(8'h40, 2);
        pulse_start(8'h40, 2);
        wait_idle(600);
        ready_mode = 0;

        // Core busy gating.
        rif.i_core_busy = 1'b1;
        model(8'h80, 1);
        pulse_start(8'h80, 1);
        repeat (10) begin
            @(posedge clk); #1;
            chk("gate_mode", 64'(rif.o_inputmode), 64'(INPUT_COORD_CORE));
            chk("gate_valid", 64'(rif.o_valid), 64'd0);
        end
        rif.i_core_busy = 1'b0;
        n = 0;
        while (!rif.o_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("gate_latency", 64'(n), 64'(RD_LAT + 1));
        wait_idle(200);

        // Address wrap 255 -> 0.
        model(8'hFF, 2);
        pulse_start(8'hFF, 2);
        wait_idle(400);

        // Zero count: immediate done, nothing streamed.
        exp_done++;
        pulse_start(8'h22, 0);
        chk("zero_done", 64'(rif.o_done), 64'd1);
        chk("zero_valid", 64'(rif.o_valid), 64'd0);
        @(posedge clk); #1;
        chk("zero_done_end", 64'(rif.o_done), 64'd0);
        chk("zero_busy", 64'(rif.o_busy), 64'd0);
        wait_idle(50);

        // Start while sending is ignored.
        model(8'h05, 1);
        b0 = beat_cnt;
        pulse_start(8'h05, 1);
        wait_beats(b0 + 5, 200);
        pulse_start(8'h90, 3);
        wait_idle(300);
        repeat (30) @(posedge clk);
        #1;
        chk("ignored_start_busy", 64'(rif.o_busy), 64'd0);

        // Reset mid-stream around beat 10.
        model(8'h33, 1);
        b0 = beat_cnt;
        pulse_start(8'h33, 1);
        wait_beats(b0 + 10, 200);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(rif.o_valid), 64'd0);
        chk("mid_rst_busy", 64'(rif.o_busy), 64'd0);
        chk("mid_rst_done", 64'(rif.o_done), 64'd0);
        chk("mid_rst_data", rif.o_data, 64'd0);
        chk("mid_rst_raddr", 64'(rif.o_raddr), 64'd0);
        chk("mid_rst_mode", 64'(rif.o_inputmode), 64'(INPUT_COORD_CORE));
        exp_q.delete();
        addr_q.delete();
        exp_done--;
        dsnap = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_done", 64'(done_cnt), 64'(dsnap));

        // Randomized runs with random backpressure and core busy.
        ready_mode = 2;
        for (int r = 0; r < 6; r++) begin
            logic [RAM_ADDR_SIZE-1:0] base;
            int num;
            base = RAM_ADDR_SIZE'($urandom);
            num  = int'($urandom_range(1, 3));
            rif.i_core_busy = 1'($urandom_range(0, 1));
            fork
                begin
                    repeat ($urandom_range(1, 8)) @(posedge clk);
                    #1;
                    rif.i_core_busy = 1'b0;
                end
            join_none
            model(base, num);
            pulse_start(base, num);
            wait_idle(1500);
        end
        ready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
